// File: rtl/snow64_bfloat16_vec_slt_seq_pkg.sv
// Shared types for the sequential bfloat16 vector compare.
// Contents:
//   - Default lane count and lane width.
//   - VecCmpOp: the compare operation.
//   - VecCmpState: the sequencer states.
//   - PortIn_BinOp / PortOut_BinOp: the bundles that drive the lane comparator
//     and carry its result back.
package PkgSnow64BFloat16;

  localparam int NUM_LANES_DEF   = 16;
  localparam int WIDTH__LANE_DEF = 16;

  typedef enum logic {
    VecCmpOpLt = 1'b0,
    VecCmpOpGt = 1'b1
  } VecCmpOp;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } VecCmpState;

  typedef struct packed {
    logic                       start;
    logic [WIDTH__LANE_DEF-1:0] a;
    logic [WIDTH__LANE_DEF-1:0] b;
  } PortIn_BinOp;

  typedef struct packed {
    logic data_valid;
    logic data;
  } PortOut_BinOp;

endpackage

// File: rtl/snow64_bfloat16_vec_slt_seq_if.sv
// Command/result bundle for snow64_bfloat16_vec_slt_seq.
// Signals:
//   in_start, in_op, in_a, in_b    command from the requester
//   out_can_accept_cmd             high while the engine is idle
//   out_data_valid, out_data       one-cycle completion pulse and result mask
//   in_broadcast_b                 present only with SNOW64_BFLOAT16_VEC_CMP_BROADCAST_EN
// Modports:
//   master  the requester side
//   slave   the compare engine side
interface snow64_bfloat16_vec_slt_seq_if #(
  parameter int NUM_LANES   = 16,
  parameter int WIDTH__LANE = 16
);
  logic                             in_start;
  logic                             in_op;
  logic [NUM_LANES*WIDTH__LANE-1:0] in_a;
  logic [NUM_LANES*WIDTH__LANE-1:0] in_b;
`ifdef SNOW64_BFLOAT16_VEC_CMP_BROADCAST_EN
  logic                             in_broadcast_b;
`endif
  logic                             out_can_accept_cmd;
  logic                             out_data_valid;
  logic [NUM_LANES-1:0]             out_data;

  modport master (
    output in_start, in_op, in_a, in_b,
`ifdef SNOW64_BFLOAT16_VEC_CMP_BROADCAST_EN
    output in_broadcast_b,
`endif
    input  out_can_accept_cmd, out_data_valid, out_data
  );

  modport slave (
    input  in_start, in_op, in_a, in_b,
`ifdef SNOW64_BFLOAT16_VEC_CMP_BROADCAST_EN
    input  in_broadcast_b,
`endif
    output out_can_accept_cmd, out_data_valid, out_data
  );
endinterface

// File: rtl/snow64_bfloat16_vec_slt_seq_slt.sv
// Snow64BFloat16Slt: single-lane bfloat16 less-than with a registered result.
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   i_bin_op  start strobe and operands a, b
//   o_bin_op  registered a<b and a valid flag delayed one edge from start
module Snow64BFloat16Slt
  import PkgSnow64BFloat16::*;
(
  input  logic         clk,
  input  logic         rst,
  input  PortIn_BinOp  i_bin_op,
  output PortOut_BinOp o_bin_op
);

  logic r_valid;
  logic r_data;

  // Sign/magnitude ordering: +0 and -0 are equal, negatives order by
  // descending magnitude. NaN inputs fall through the magnitude path.
  function automatic logic f_slt(logic [WIDTH__LANE_DEF-1:0] a,
                                 logic [WIDTH__LANE_DEF-1:0] b);
    logic [WIDTH__LANE_DEF-2:0] mag_a;
    logic [WIDTH__LANE_DEF-2:0] mag_b;
    mag_a = a[WIDTH__LANE_DEF-2:0];
    mag_b = b[WIDTH__LANE_DEF-2:0];
    if ((mag_a == '0) && (mag_b == '0))
      return 1'b0;
    else if (a[WIDTH__LANE_DEF-1] != b[WIDTH__LANE_DEF-1])
      return a[WIDTH__LANE_DEF-1];
    else if (a[WIDTH__LANE_DEF-1])
      return mag_a > mag_b;
    else
      return mag_a < mag_b;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_valid <= 1'b0;
    else     r_valid <= i_bin_op.start;
  end

  always_ff @(posedge clk) begin
    if (i_bin_op.start) r_data <= f_slt(i_bin_op.a, i_bin_op.b);
  end

  assign o_bin_op.data_valid = r_valid;
  assign o_bin_op.data       = r_data;

endmodule

// File: rtl/snow64_bfloat16_vec_slt_seq.sv
// snow64_bfloat16_vec_slt_seq: per-lane bfloat16 LT/GT over a vector, one lane
// per cycle through a single registered comparator.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  command/result bundle (slave modport)
// Optional feature: define SNOW64_BFLOAT16_VEC_CMP_BROADCAST_EN to add
// in_broadcast_b, which replicates lane 0 of in_b across all lanes.
module snow64_bfloat16_vec_slt_seq
  import PkgSnow64BFloat16::*;
#(
  parameter int NUM_LANES   = NUM_LANES_DEF,
  parameter int WIDTH__LANE = WIDTH__LANE_DEF
) (
  input logic                      clk,
  input logic                      rst,
  snow64_bfloat16_vec_slt_seq_if.slave bus
);

  localparam int CNT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int VEC_W = NUM_LANES * WIDTH__LANE;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

  VecCmpState             r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_wr_idx;
  logic                   r_wr_vld;
  logic [NUM_LANES-1:0]   r_out_data;
  logic [VEC_W-1:0]       r_a;
  logic [VEC_W-1:0]       r_b;
  VecCmpOp                r_op;

  logic                   w_accept;
  logic                   w_issue;
  logic                   w_can_accept;
  logic                   w_data_valid;
  logic                   w_bcast;
  logic [VEC_W-1:0]       w_b_src;
  logic [WIDTH__LANE-1:0] w_lane_a;
  logic [WIDTH__LANE-1:0] w_lane_b;
  PortIn_BinOp            w_slt_in;
  PortOut_BinOp           w_slt_out;
  logic                   w_unused_slt_vld;

`ifdef SNOW64_BFLOAT16_VEC_CMP_BROADCAST_EN
  assign w_bcast = bus.in_broadcast_b;
`else
  assign w_bcast = 1'b0;
`endif

  assign w_b_src = w_bcast ? {NUM_LANES{bus.in_b[WIDTH__LANE-1:0]}} : bus.in_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_can_accept = 1'b0;
    w_data_valid = 1'b0;
    case (r_state)
      StIdle: begin
        w_can_accept = 1'b1;
        if (bus.in_start) begin
          w_accept    = 1'b1;
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        w_issue = 1'b1;
        if (r_cnt == LAST_LANE) w_state_nxt = StDrain;
      end
      StDrain: w_state_nxt = StDone;
      StDone: begin
        w_data_valid = 1'b1;
        w_state_nxt  = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Operand capture: GT is realised as LT with a and b swapped.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a  <= bus.in_a;
      r_b  <= w_b_src;
      r_op <= VecCmpOp'(bus.in_op);
    end
  end

  assign w_lane_a = r_a[int'(r_cnt)*WIDTH__LANE +: WIDTH__LANE];
  assign w_lane_b = r_b[int'(r_cnt)*WIDTH__LANE +: WIDTH__LANE];

  always_comb begin
    w_slt_in.start = w_issue;
    w_slt_in.a     = (r_op == VecCmpOpGt) ? w_lane_b : w_lane_a;
    w_slt_in.b     = (r_op == VecCmpOpGt) ? w_lane_a : w_lane_b;
  end

  Snow64BFloat16Slt u_slt (
    .clk      (clk),
    .rst      (rst),
    .i_bin_op (w_slt_in),
    .o_bin_op (w_slt_out)
  );

  assign w_unused_slt_vld = w_slt_out.data_valid;

  // Issue -> comparator register -> result mask: r_wr_idx trails r_cnt by one
  // edge so each lane lands in out_data two edges after it is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_wr_idx   <= '0;
      r_wr_vld   <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_wr_vld <= w_issue;
      r_wr_idx <= r_cnt;
      if (w_accept) begin
        r_cnt      <= '0;
        r_out_data <= '0;
      end else begin
        if (w_issue) r_cnt <= r_cnt + 1'b1;
        if (r_wr_vld) r_out_data[r_wr_idx] <= w_slt_out.data;
      end
    end
  end

  assign bus.out_can_accept_cmd = w_can_accept;
  assign bus.out_data_valid     = w_data_valid;
  assign bus.out_data           = r_out_data;

endmodule

// File: tb/tb_snow64_bfloat16_vec_slt_seq.sv
module tb_snow64_bfloat16_vec_slt_seq;
  import PkgSnow64BFloat16::*;

  localparam int NL = 16;
  localparam int WL = 16;
  localparam int VW = NL * WL;

  logic clk;
  logic rst;

  snow64_bfloat16_vec_slt_seq_if #(.NUM_LANES(NL), .WIDTH__LANE(WL)) bus ();

  snow64_bfloat16_vec_slt_seq #(.NUM_LANES(NL), .WIDTH__LANE(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] splat(input logic [15:0] even, input logic [15:0] odd);
    logic [VW-1:0] v;
    for (int k = 0; k < NL; k++) v[k*WL +: WL] = (k % 2 == 1) ? odd : even;
    return v;
  endfunction

  typedef struct {
    logic          op;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [15:0]   exp;
    logic          bcast;
  } vec_t;

  // Run one command to completion: checks acceptance clears the mask, the
  // handshake drops, latency to the valid pulse, pulse count and final mask.
  task automatic run_cmd(input string name, input vec_t v, input bit restart5);
    int lat;
    int pulses;
    @(negedge clk);
    chk({name, "_idle"}, {31'd0, bus.out_can_accept_cmd}, 32'd1);
    bus.in_start = 1'b1;
    bus.in_op    = v.op;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
`ifdef SNOW64_BFLOAT16_VEC_CMP_BROADCAST_EN
    bus.in_broadcast_b = v.bcast;
`endif
    @(posedge clk);
    #1;
    bus.in_start = 1'b0;
    bus.in_a     = ~v.a;
    bus.in_b     = ~v.b;
    bus.in_op    = ~v.op;
`ifdef SNOW64_BFLOAT16_VEC_CMP_BROADCAST_EN
    bus.in_broadcast_b = ~v.bcast;
`endif
    chk({name, "_cleared"}, {16'd0, bus.out_data}, 32'd0);
    lat = 0;
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_data_valid) begin
        pulses++;
        if (lat == 0) lat = n;
      end
      if (n == 1) chk({name, "_busy"}, {31'd0, bus.out_can_accept_cmd}, 32'd0);
      if (restart5 && n == 4) bus.in_start = 1'b1;
      if (restart5 && n == 5) bus.in_start = 1'b0;
    end
    chk({name, "_latency"}, lat, 32'd17);
    chk({name, "_pulses"}, pulses, 32'd1);
    chk({name, "_data"}, {16'd0, bus.out_data}, {16'd0, v.exp});
    chk({name, "_idle_after"}, {31'd0, bus.out_can_accept_cmd}, 32'd1);
  endtask

  vec_t tv[8];
  vec_t vb;
  logic [VW-1:0] a2, b2;
  int pulses_rst;

  initial begin
    rst = 1'b1;
    bus.in_start = 1'b0;
    bus.in_op    = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
`ifdef SNOW64_BFLOAT16_VEC_CMP_BROADCAST_EN
    bus.in_broadcast_b = 1'b0;
`endif

    a2 = splat(16'h3F80, 16'h3F80);
    b2 = splat(16'h3F80, 16'h3F80);
    a2[15:0]  = 16'h0000; b2[15:0]  = 16'h8000;
    a2[31:16] = 16'h8000; b2[31:16] = 16'h0000;

    tv[0] = '{1'b0, splat(16'h3F80, 16'h3F80), splat(16'h4000, 16'h4000), 16'hFFFF, 1'b0};
    tv[1] = '{1'b1, splat(16'h3F80, 16'h3F80), splat(16'h4000, 16'h4000), 16'h0000, 1'b0};
    tv[2] = '{1'b0, a2, b2, 16'h0000, 1'b0};
    tv[3] = '{1'b1, a2, b2, 16'h0000, 1'b0};
    tv[4] = '{1'b0, splat(16'hBF80, 16'hC000), splat(16'hC000, 16'hBF80), 16'hAAAA, 1'b0};
    tv[5] = '{1'b1, splat(16'hBF80, 16'hC000), splat(16'hC000, 16'hBF80), 16'h5555, 1'b0};
    tv[6] = '{1'b0, splat(16'h3F80, 16'hBF80), splat(16'h0000, 16'h0000), 16'hAAAA, 1'b0};
    tv[7] = '{1'b1, splat(16'h3F80, 16'hBF80), splat(16'h0000, 16'h0000), 16'h5555, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_can_accept", {31'd0, bus.out_can_accept_cmd}, 32'd1);
    chk("rst_valid", {31'd0, bus.out_data_valid}, 32'd0);
    chk("rst_data", {16'd0, bus.out_data}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_cmd($sformatf("vec%0d", i), tv[i], 1'b0);

    // A second start inside ISSUE must not be taken.
    run_cmd("restart5", tv[4], 1'b1);

    // Reset at edge 8 aborts the command.
    @(negedge clk);
    bus.in_start = 1'b1;
    bus.in_op    = 1'b0;
    bus.in_a     = tv[0].a;
    bus.in_b     = tv[0].b;
    @(posedge clk);
    #1;
    bus.in_start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("partial_mask_e8", {16'd0, bus.out_data}, 32'h0000007F);
    rst = 1'b1;
    #1;
    chk("abort_can_accept", {31'd0, bus.out_can_accept_cmd}, 32'd1);
    chk("abort_data", {16'd0, bus.out_data}, 32'd0);
    chk("abort_valid", {31'd0, bus.out_data_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses_rst = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_data_valid) pulses_rst++;
    end
    chk("abort_no_pulse", pulses_rst, 32'd0);
    chk("abort_idle", {31'd0, bus.out_can_accept_cmd}, 32'd1);

    // Normal operation resumes after the abort.
    run_cmd("post_abort", tv[6], 1'b0);

`ifdef SNOW64_BFLOAT16_VEC_CMP_BROADCAST_EN
    vb.op    = 1'b0;
    vb.a     = splat(16'h3F80, 16'h3F80);
    vb.b     = '0;
    vb.b[15:0] = 16'h4000;
    vb.exp   = 16'hFFFF;
    vb.bcast = 1'b1;
    run_cmd("bcast_on", vb, 1'b0);
    vb.bcast = 1'b0;
    vb.exp   = 16'h0001;
    run_cmd("bcast_off", vb, 1'b0);
`else
    vb = tv[0];
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snow64_bfloat16_vec_slt_seq.md
SNOW64_BFLOAT16_VEC_SLT_SEQ -- requirements
Module: snow64_bfloat16_vec_slt_seq

Interface
REQ-001 SHALL have parameter NUM_LANES, default 16, number of bfloat16 lanes per vector operand.
REQ-002 SHALL have parameter WIDTH__LANE, default 16, bits per lane (bfloat16 encoding).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_start  input  1  command strobe, sampled only while out_can_accept_cmd=1.
REQ-006 SHALL have port in_op  input  1  0=LT (a<b per lane), 1=GT (a>b per lane).
REQ-007 SHALL have port in_a  input  NUM_LANES*WIDTH__LANE  vector operand a; lane k at bits [16k+15:16k].
REQ-008 SHALL have port in_b  input  NUM_LANES*WIDTH__LANE  vector operand b; same lane layout.
REQ-009 SHALL have port out_can_accept_cmd  output  1  high when idle.
REQ-010 SHALL have port out_data_valid  output  1  one-cycle pulse when out_data is complete.
REQ-011 SHALL have port out_data  output  NUM_LANES  per-lane result mask; bit k = result of lane k.

Function
REQ-012 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-013 IDLE: out_can_accept_cmd=1; on in_start=1, latch in_a, in_b, in_op; clear lane counter to 0; go to ISSUE.
REQ-014 ISSUE: each cycle present lane[counter] to the compare sub-module with start=1; for GT, swap a and b before issue; increment counter; after lane NUM_LANES-1, go to DRAIN.
REQ-015 Compare sub-module SHALL register its result one edge after issue; lane k result SHALL be written into out_data bit k on the edge after it is registered.
REQ-016 DRAIN: capture the final lane result; go to DONE.
REQ-017 DONE: out_data_valid=1 for exactly this one cycle; go to IDLE.
REQ-018 out_data_valid SHALL first be high NUM_LANES+1 edges after the edge that samples in_start (17 for defaults).
REQ-019 out_can_accept_cmd SHALL be 0 in ISSUE, DRAIN, and DONE; in_start in those states SHALL be ignored, with no latching or queuing.
REQ-020 out_data SHALL be cleared to 0 on accepting a command and SHALL hold its final value after DONE until the next accepted command.
REQ-021 Per-lane compare semantics SHALL be sign/magnitude bfloat16 less-than; +0 and -0 compare equal (result 0 both ways); NaN handling is undefined.
REQ-022 In-flight operand changes on in_a/in_b after acceptance SHALL NOT affect the result.

Reset
REQ-023 On rst=1 (any state, asynchronously): state=IDLE, counter=0, out_data=0, out_data_valid=0, out_can_accept_cmd=1.
REQ-024 Reset mid-operation SHALL abort the command; no out_data_valid pulse for it.

Configuration
REQ-025 Macro SNOW64_BFLOAT16_VEC_CMP_BROADCAST_EN: when defined, add port in_broadcast_b (input, 1); when high at acceptance, lane 0 of in_b SHALL be used as b for every lane.
REQ-026 Without the macro, port in_broadcast_b SHALL be absent and behaviour SHALL equal in_broadcast_b=0.

Structure
REQ-027 PkgSnow64BFloat16 SHALL hold the VecCmpOp enum (LT=0, GT=1), the state enum, and the NUM_LANES/WIDTH__LANE defaults.
REQ-028 One sub-module SHALL be instantiated: Snow64BFloat16Slt (single-cycle registered compare), driven through its PortIn_BinOp/PortOut_BinOp; its data_valid is unused.
REQ-029 Lane counter width SHALL be clog2(NUM_LANES).

Verification
REQ-030 All lanes a=0x3F80 (1.0), b=0x4000 (2.0), op=LT -> out_data=0xFFFF, valid pulse 17 edges after start.
REQ-031 Same operands, op=GT -> out_data=0x0000.
REQ-032 Lane0 a=0x0000, b=0x8000; lane1 a=0x8000, b=0x0000; other lanes a=b=0x3F80; op=LT -> out_data=0x0000.
REQ-033 Even lanes a=0xBF80, b=0xC000; odd lanes a=0xC000, b=0xBF80; op=LT -> out_data=0xAAAA.
REQ-034 Second in_start at edge 5 ignored (single valid pulse); separate run asserts rst at edge 8 -> no valid pulse, out_can_accept_cmd=1 and out_data=0 immediately.
REQ-035 With macro: in_broadcast_b=1, b lane0=0x4000, other b lanes=0x0000, all a=0x3F80, op=LT -> out_data=0xFFFF.
